// File: rtl/shift_seq_ctrl.sv
// Serial shift sequencer: shifts a parallel word out on ser_out while capturing ser_in,
// one bit every DIV clocks, then holds the captured word until the consumer takes it.
module shift_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  input  logic             ser_in,
  output logic             shift_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);
  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [7:0]       DIV_LAST = 8'(DIV - 1);
  localparam bit               DIV_ONE  = (DIV == 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-1:0] rx_reg;
  logic [WIDTH-1:0] tx_next;
  logic [WIDTH-1:0] rx_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [7:0]       div_cnt;

  always_comb begin
    if (MSB_FIRST) begin
      tx_next = {tx_reg[WIDTH-2:0], 1'b0};
      rx_next = {rx_reg[WIDTH-2:0], ser_in};
    end else begin
      tx_next = {1'b0, tx_reg[WIDTH-1:1]};
      rx_next = {ser_in, rx_reg[WIDTH-1:1]};
    end
  end

  // Outside SHIFT the line is parked low.
  assign ser_out = (state == SHIFT) & (MSB_FIRST ? tx_reg[WIDTH-1] : tx_reg[0]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      shift_en  <= 1'b0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= SHIFT;
            tx_reg   <= in_data;
            bit_cnt  <= '0;
            div_cnt  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            shift_en <= DIV_ONE;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            tx_reg  <= tx_next;
            rx_reg  <= rx_next;
            bit_cnt <= bit_cnt + 1'b1;
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state     <= HOLD;
              out_data  <= rx_next;
              out_valid <= 1'b1;
              shift_en  <= 1'b0;
            end else begin
              shift_en <= DIV_ONE;
            end
          end else begin
            // shift_en is registered, so it is raised one cycle ahead of the wrap.
            div_cnt  <= div_cnt + 8'd1;
            shift_en <= ((div_cnt + 8'd1) == DIV_LAST);
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: shift register length and transfer word width in bits; legal range 2..32.
REQ-002 Parameter DIV, default 1: clock cycles per shifted bit; legal range 1..255.
REQ-003 Parameter MSB_FIRST, default 0: 0 = LSB shifted out and in first; 1 = MSB first.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; 0 sampled at a rising clk edge resets the block.
REQ-006 in_valid  input  1  parallel word offered for transfer.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_data  input  WIDTH  parallel word to shift out.
REQ-009 ser_out  output  1  serial data to the external shift register or line.
REQ-010 ser_in  input  1  serial data returned from the external shift register or line.
REQ-011 shift_en  output  1  one-cycle strobe; the external register shifts on the edge ending this cycle.
REQ-012 out_valid  output  1  captured word available.
REQ-013 out_ready  input  1  consumer takes the captured word.
REQ-014 out_data  output  WIDTH  word captured from ser_in.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT, HOLD.
REQ-017 IDLE: in_ready=1. On in_valid=1, the block loads tx_reg<=in_data, clears bit_cnt and div_cnt, and enters SHIFT.
REQ-018 SHIFT: ser_out = tx_reg[0] (MSB_FIRST=0) or tx_reg[WIDTH-1] (MSB_FIRST=1); in_ready=0.
REQ-019 SHIFT: div_cnt counts 0..DIV-1 and wraps. shift_en=1 exactly in cycles where div_cnt==DIV-1.
REQ-020 On the edge ending a shift_en cycle, the block shifts tx_reg one position toward the output end, inserts ser_in into rx_reg at the input end (MSB_FIRST=0: rx_reg<={ser_in, rx_reg[WIDTH-1:1]}; MSB_FIRST=1: rx_reg<={rx_reg[WIDTH-2:0], ser_in}), and increments bit_cnt.
REQ-021 On the edge completing the WIDTH-th shift, the block enters HOLD and registers out_data<=final rx_reg value. out_valid rises exactly WIDTH*DIV edges after the accepting edge.
REQ-022 HOLD: out_valid=1, in_ready=0, shift_en=0. out_data and out_valid stay stable while out_ready=0.
REQ-023 HOLD with out_ready=1: the word is consumed on that edge and the FSM returns to IDLE. The next word can be accepted at the following edge at the earliest.
REQ-024 in_valid is ignored outside IDLE. tx_reg is never modified except by REQ-017/REQ-020.
REQ-025 ser_out=0 in IDLE and HOLD. shift_en=0 outside SHIFT.
REQ-026 bit_cnt is ceil(log2(WIDTH+1)) bits wide and div_cnt is 8 bits wide; neither overflows for legal parameters.
REQ-027 out_ready=1 while out_valid=0 has no effect.

Reset
REQ-028 A reset edge (reset=0) SHALL force: state=IDLE, in_ready=1 from the next cycle, out_valid=0, out_data=0, ser_out=0, shift_en=0, busy=0, tx_reg=0, rx_reg=0, bit_cnt=0, div_cnt=0.
REQ-029 Reset takes priority over every other input in every state. A transfer interrupted mid-SHIFT or mid-HOLD is discarded with no out_valid pulse.
REQ-030 While reset=0, in_valid is not accepted.

Verification
REQ-031 Loopback (ser_out tied to ser_in), WIDTH=4, DIV=1, in_data=4'b1011 accepted at edge 0 → shift_en high for 4 consecutive cycles, ser_out sequence 1,1,0,1, out_valid rises at edge 4, out_data=4'b1011.
REQ-032 External 4-stage serial register preloaded with 0000, in_data=4'b0110, MSB_FIRST=1 → ser_out sequence 0,1,1,0; out_data=4'b0000; external register ends holding 0110.
REQ-033 DIV=3, WIDTH=4 → shift_en pulses exactly at cycles 3, 6, 9, 12 after the accepting edge (counting the first cycle after it as cycle 1); out_valid rises at edge 12.
REQ-034 out_ready held low 10 cycles in HOLD while in_valid=1 with new data → out_valid and out_data stay constant, in_ready=0, no new transfer starts. out_ready=1 → IDLE, and the new word is accepted on the next edge.
REQ-035 reset=0 asserted after the 2nd shift of a transfer → next cycle busy=0, out_valid=0, ser_out=0. A fresh transfer after release completes normally with correct data.
